// File: rtl/mii_sched_pkg.sv
// Shared definitions for the MII frame scheduler and the frame generator it drives:
// scheduler states, XGMII-style control codes and beat decoders.
package mii_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        WAIT_EOF = 2'd2,
        GAP      = 2'd3
    } state_e;

    localparam logic [7:0] IDLE_CODE  = 8'h07;
    localparam logic [7:0] START_CODE = 8'hFB;
    localparam logic [7:0] EOF_CODE   = 8'hFD;
    localparam logic [7:0] NO_PADDING = 8'd2;

    // Start of frame is only legal in lane 0.
    function automatic logic is_sof(input logic [63:0] txd, input logic [7:0] ctrl);
        return ctrl[0] && (txd[7:0] == START_CODE);
    endfunction

    function automatic logic has_eof(input logic [63:0] txd, input logic [7:0] ctrl);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ctrl[i] && (txd[8*i +: 8] == EOF_CODE)) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/mii_frame_scheduler_if.sv
// Bundle between the traffic sources / frame generator (master) and the scheduler (slave).
// Handshake: i_req[k] is a level held by source k until o_gnt[k] rises; o_gnt stays high
// for the whole frame, and a frame is complete on the single-cycle o_done pulse.
interface mii_frame_scheduler_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    i_req;
    logic [16*N_REQ-1:0] i_len;
    logic [N_REQ-1:0]    i_nopad;
    logic [63:0]         i_gen_txd;
    logic [7:0]          i_gen_ctrl;
    logic                i_clr_err;

    logic [N_REQ-1:0]    o_gnt;
    logic [2:0]          o_active_id;
    logic                o_gen_en;
    logic [15:0]         o_payload_length;
    logic [7:0]          o_interrupt;
    logic                o_done;
    logic                o_busy;
    logic [15:0]         o_frame_cnt;
    logic                o_err_len;
    logic                o_err_timeout;

    modport master (
        output i_req, i_len, i_nopad, i_gen_txd, i_gen_ctrl, i_clr_err,
        input  o_gnt, o_active_id, o_gen_en, o_payload_length, o_interrupt,
               o_done, o_busy, o_frame_cnt, o_err_len, o_err_timeout
    );

    modport slave (
        input  i_req, i_len, i_nopad, i_gen_txd, i_gen_ctrl, i_clr_err,
        output o_gnt, o_active_id, o_gen_en, o_payload_length, o_interrupt,
               o_done, o_busy, o_frame_cnt, o_err_len, o_err_timeout
    );
endinterface

// File: rtl/mii_frame_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first request after the last served index.
// The pointer moves only on i_advance, so a held request is not skipped by idle cycles.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_advance,
    output logic             o_valid,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] last_d;
    logic [IDX_W-1:0] cand;
    int               pos;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        cand    = '0;
        pos     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos = int'(last_q) + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            cand = IDX_W'(pos);
            if (!o_valid && i_req[cand]) begin
                o_valid = 1'b1;
                o_idx   = cand;
            end
        end
        o_gnt  = o_valid ? ({{(N_REQ-1){1'b0}}, 1'b1} << o_idx) : '0;
        last_d = (i_advance && o_valid) ? o_idx : last_q;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) last_q <= IDX_W'(N_REQ - 1);
        else          last_q <= last_d;
    end

endmodule

// File: rtl/mii_frame_scheduler.sv
// Shares one MII frame generator among N_REQ sources: round-robin grant, per-frame
// SOF/EOF tracking with timeout, and an enforced inter-packet gap.
module mii_frame_scheduler
    import mii_sched_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int MAX_PAYLOAD    = 1500,
    parameter int IPG_MIN_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         i_rst_n,
    mii_frame_scheduler_if.slave         bus,
    output state_e                       o_dbg_state
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + IPG_MIN_CYCLES + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [2:0]        id_q, id_d;
    logic              gen_en_q, gen_en_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        intr_q, intr_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              err_len_q, err_len_d;
    logic              err_to_q, err_to_d;

    logic              arb_valid;
    logic              arb_advance;
    logic [N_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]  arb_idx;

    logic [15:0]       sel_len;
    logic              len_ok;
    logic              sof, eof;
    logic              timeout_hit;
    logic              finish, abort;
    logic              set_len_err, set_to_err;

    // The pointer moves on every IDLE decision, including rejected lengths.
    assign arb_advance = (state_q == IDLE) && arb_valid;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .clk       (clk),
        .i_rst_n   (i_rst_n),
        .i_req     (bus.i_req),
        .i_advance (arb_advance),
        .o_valid   (arb_valid),
        .o_gnt     (arb_gnt),
        .o_idx     (arb_idx)
    );

    always_comb begin
        sel_len = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (arb_idx == IDX_W'(k)) sel_len = bus.i_len[16*k +: 16];
        end
        len_ok      = (sel_len != 16'd0) && (sel_len <= 16'(MAX_PAYLOAD));
        sof         = is_sof(bus.i_gen_txd, bus.i_gen_ctrl);
        eof         = has_eof(bus.i_gen_txd, bus.i_gen_ctrl);
        timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        id_d        = id_q;
        len_d       = len_q;
        intr_d      = intr_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        finish      = 1'b0;
        abort       = 1'b0;
        set_len_err = 1'b0;
        set_to_err  = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    if (len_ok) begin
                        gnt_d   = arb_gnt;
                        id_d    = 3'(arb_idx);
                        len_d   = sel_len;
                        intr_d  = bus.i_nopad[arb_idx] ? NO_PADDING : 8'd0;
                        cnt_d   = '0;
                        state_d = WAIT_SOF;
                    end else begin
                        set_len_err = 1'b1;
                    end
                end
            end
            WAIT_SOF: begin
                // A short frame can start and terminate within one beat.
                if (sof && eof)       finish = 1'b1;
                else if (sof) begin
                    cnt_d   = '0;
                    state_d = WAIT_EOF;
                end
                else if (timeout_hit) abort = 1'b1;
                else                  cnt_d = cnt_q + 1'b1;
            end
            WAIT_EOF: begin
                if (eof)              finish = 1'b1;
                else if (timeout_hit) abort = 1'b1;
                else                  cnt_d = cnt_q + 1'b1;
            end
            GAP: begin
                if (cnt_q == CNT_W'(IPG_MIN_CYCLES - 1)) state_d = IDLE;
                else                                     cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (finish || abort) begin
            state_d = GAP;
            cnt_d   = '0;
            gnt_d   = '0;
        end
        if (finish) begin
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        set_to_err = abort;

        err_len_d = set_len_err | (err_len_q & ~bus.i_clr_err);
        err_to_d  = set_to_err  | (err_to_q  & ~bus.i_clr_err);
        gen_en_d  = (state_d == WAIT_SOF) || (state_d == WAIT_EOF);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gnt_q       <= '0;
            id_q        <= '0;
            gen_en_q    <= 1'b0;
            len_q       <= '0;
            intr_q      <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            err_len_q   <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            id_q        <= id_d;
            gen_en_q    <= gen_en_d;
            len_q       <= len_d;
            intr_q      <= intr_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            err_len_q   <= err_len_d;
            err_to_q    <= err_to_d;
        end
    end

    assign bus.o_gnt            = gnt_q;
    assign bus.o_active_id      = id_q;
    assign bus.o_gen_en         = gen_en_q;
    assign bus.o_payload_length = len_q;
    assign bus.o_interrupt      = intr_q;
    assign bus.o_done           = done_q;
    assign bus.o_busy           = busy_q;
    assign bus.o_frame_cnt      = frame_cnt_q;
    assign bus.o_err_len        = err_len_q;
    assign bus.o_err_timeout    = err_to_q;
    assign o_dbg_state          = state_q;

endmodule

// File: tb/tb_mii_frame_scheduler.sv
// Directed bench for mii_frame_scheduler: arbitration order, gap timing, length
// rejection, timeout, lane-qualified EOF, latched nopad and asynchronous reset.
module tb_mii_frame_scheduler;
    import mii_sched_pkg::*;

    localparam int N_REQ = 4;
    localparam int IPG   = 2;
    localparam int TO    = 256;

    localparam logic [63:0] IDLE_BEAT   = {8{8'h07}};
    localparam logic [63:0] SOF_BEAT    = {{7{8'h55}}, 8'hFB};
    localparam logic [63:0] DATA_BEAT   = {8{8'hA5}};
    localparam logic [63:0] EOF3_BEAT   = {8'h07, 8'h07, 8'h07, 8'h07, 8'hFD, 8'hA5, 8'hA5, 8'hA5};
    localparam logic [63:0] EOF7_BEAT   = {8'hFD, {7{8'hA5}}};
    localparam logic [63:0] EOF5_BEAT   = {8'h07, 8'h07, 8'hFD, {5{8'hA5}}};
    localparam logic [63:0] FD5_DATA    = {8'hA5, 8'hA5, 8'hFD, {5{8'hA5}}};
    localparam logic [63:0] SOF_EOF_BT  = {8'h07, 8'h07, 8'hFD, 8'h55, 8'h55, 8'h55, 8'h55, 8'hFB};

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_e dbg_state;
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;

    mii_frame_scheduler_if #(.N_REQ(N_REQ)) bus ();

    mii_frame_scheduler #(
        .N_REQ          (N_REQ),
        .MAX_PAYLOAD    (1500),
        .IPG_MIN_CYCLES (IPG),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .i_rst_n     (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [63:0] txd, input logic [7:0] ctrl);
        bus.i_gen_txd  = txd;
        bus.i_gen_ctrl = ctrl;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.o_gnt == '0 && n < 20);
    endtask

    task automatic check_reset(input string pfx);
        chk({pfx, "_gnt"},       64'(bus.o_gnt), 64'd0);
        chk({pfx, "_id"},        64'(bus.o_active_id), 64'd0);
        chk({pfx, "_gen_en"},    64'(bus.o_gen_en), 64'd0);
        chk({pfx, "_len"},       64'(bus.o_payload_length), 64'd0);
        chk({pfx, "_intr"},      64'(bus.o_interrupt), 64'd0);
        chk({pfx, "_done"},      64'(bus.o_done), 64'd0);
        chk({pfx, "_busy"},      64'(bus.o_busy), 64'd0);
        chk({pfx, "_frame_cnt"}, 64'(bus.o_frame_cnt), 64'd0);
        chk({pfx, "_err_len"},   64'(bus.o_err_len), 64'd0);
        chk({pfx, "_err_to"},    64'(bus.o_err_timeout), 64'd0);
        chk({pfx, "_state"},     64'(dbg_state), 64'(IDLE));
    endtask

    initial begin
        int n;
        int exp_id[8] = '{1, 2, 3, 0, 1, 2, 3, 0};

        bus.i_req     = '0;
        bus.i_len     = '0;
        bus.i_nopad   = '0;
        bus.i_clr_err = 1'b0;
        beat(IDLE_BEAT, 8'hFF);

        // Reset values
        tick(2);
        check_reset("rst");
        rst_n = 1'b1;
        tick();

        // Single frame from source 0, EOF in lane 3
        bus.i_req        = 4'b0001;
        bus.i_len[15:0]  = 16'd64;
        tick();
        chk("t1_gnt",    64'(bus.o_gnt), 64'h1);
        chk("t1_len",    64'(bus.o_payload_length), 64'd64);
        chk("t1_gen_en", 64'(bus.o_gen_en), 64'd1);
        chk("t1_intr",   64'(bus.o_interrupt), 64'd0);
        chk("t1_state",  64'(dbg_state), 64'(WAIT_SOF));
        bus.i_req = '0;
        beat(SOF_BEAT, 8'h01);
        tick();
        chk("t1_sof_state", 64'(dbg_state), 64'(WAIT_EOF));
        chk("t1_sof_gnt",   64'(bus.o_gnt), 64'h1);
        beat(DATA_BEAT, 8'h00);
        tick();
        chk("t1_data_done", 64'(bus.o_done), 64'd0);
        beat(EOF3_BEAT, 8'hF8);
        tick();
        chk("t1_done",   64'(bus.o_done), 64'd1);
        chk("t1_cnt",    64'(bus.o_frame_cnt), 64'd1);
        chk("t1_gnt0",   64'(bus.o_gnt), 64'h0);
        chk("t1_gen_en0", 64'(bus.o_gen_en), 64'd0);
        chk("t1_busy",   64'(bus.o_busy), 64'd1);
        chk("t1_gap",    64'(dbg_state), 64'(GAP));

        // All four requesting: rotation continues after source 0, gap of IPG+1 cycles
        beat(IDLE_BEAT, 8'hFF);
        bus.i_req = 4'b1111;
        bus.i_len = {16'd400, 16'd300, 16'd200, 16'd100};
        for (int f = 0; f < 8; f++) begin
            wait_gnt(n);
            chk($sformatf("rr%0d_latency", f), 64'(n), 64'(IPG + 1));
            chk($sformatf("rr%0d_gnt", f),     64'(bus.o_gnt), 64'(1 << exp_id[f]));
            chk($sformatf("rr%0d_id", f),      64'(bus.o_active_id), 64'(exp_id[f]));
            chk($sformatf("rr%0d_len", f),     64'(bus.o_payload_length), 64'(100 * (exp_id[f] + 1)));
            beat(SOF_BEAT, 8'h01);
            tick();
            beat(EOF7_BEAT, 8'h80);
            tick();
            chk($sformatf("rr%0d_done", f), 64'(bus.o_done), 64'd1);
            chk($sformatf("rr%0d_cnt", f),  64'(bus.o_frame_cnt), 64'(f + 2));
            beat(IDLE_BEAT, 8'hFF);
            if (f == 7) bus.i_req = '0;
        end
        tick(3);
        chk("rr_idle_busy",  64'(bus.o_busy), 64'd0);
        chk("rr_idle_state", 64'(dbg_state), 64'(IDLE));

        // Length 0 on source 2 is rejected; source 3 granted next cycle
        bus.i_len = {16'd64, 16'd0, 16'd300, 16'd100};
        bus.i_req = 4'b1100;
        tick();
        chk("len0_err", 64'(bus.o_err_len), 64'd1);
        chk("len0_gnt", 64'(bus.o_gnt), 64'h0);
        chk("len0_busy", 64'(bus.o_busy), 64'd0);
        tick();
        chk("len0_next_gnt", 64'(bus.o_gnt), 64'h8);
        chk("len0_next_len", 64'(bus.o_payload_length), 64'd64);
        bus.i_req = '0;
        beat(SOF_EOF_BT, 8'hE1);
        tick();
        chk("sofeof_done", 64'(bus.o_done), 64'd1);
        chk("sofeof_cnt",  64'(bus.o_frame_cnt), 64'd10);
        chk("sofeof_gnt",  64'(bus.o_gnt), 64'h0);
        beat(IDLE_BEAT, 8'hFF);
        bus.i_clr_err = 1'b1;
        tick();
        chk("clr_err_len", 64'(bus.o_err_len), 64'd0);
        bus.i_clr_err = 1'b0;
        tick();

        // Length 1501 on source 2 rejected; source 3 granted, then never sees FB
        bus.i_len[47:32] = 16'd1501;
        bus.i_req = 4'b1100;
        tick();
        chk("len1501_err", 64'(bus.o_err_len), 64'd1);
        chk("len1501_gnt", 64'(bus.o_gnt), 64'h0);
        tick();
        chk("len1501_next_gnt", 64'(bus.o_gnt), 64'h8);
        bus.i_req = '0;
        tick(TO - 1);
        chk("to_pre_err",   64'(bus.o_err_timeout), 64'd0);
        chk("to_pre_gnt",   64'(bus.o_gnt), 64'h8);
        chk("to_pre_state", 64'(dbg_state), 64'(WAIT_SOF));
        tick();
        chk("to_err",    64'(bus.o_err_timeout), 64'd1);
        chk("to_gnt",    64'(bus.o_gnt), 64'h0);
        chk("to_done",   64'(bus.o_done), 64'd0);
        chk("to_cnt",    64'(bus.o_frame_cnt), 64'd10);
        chk("to_gen_en", 64'(bus.o_gen_en), 64'd0);
        chk("to_state",  64'(dbg_state), 64'(GAP));
        bus.i_clr_err = 1'b1;
        tick();
        chk("clr_to_err",  64'(bus.o_err_timeout), 64'd0);
        chk("clr_len_err", 64'(bus.o_err_len), 64'd0);
        bus.i_clr_err = 1'b0;

        // Source 1, nopad, len 20; EOF in lane 5 only when ctrl[5] is set
        bus.i_req        = 4'b0010;
        bus.i_len[31:16] = 16'd20;
        bus.i_nopad      = 4'b0010;
        wait_gnt(n);
        chk("np_latency", 64'(n), 64'd2);
        chk("np_gnt",     64'(bus.o_gnt), 64'h2);
        chk("np_id",      64'(bus.o_active_id), 64'd1);
        chk("np_intr",    64'(bus.o_interrupt), 64'd2);
        chk("np_len",     64'(bus.o_payload_length), 64'd20);
        bus.i_len[31:16] = 16'd99;
        bus.i_nopad      = '0;
        bus.i_req        = '0;
        beat(SOF_BEAT, 8'h01);
        tick();
        chk("np_sof_state", 64'(dbg_state), 64'(WAIT_EOF));
        beat(FD5_DATA, 8'h00);
        tick();
        chk("np_fd_noctrl_done",  64'(bus.o_done), 64'd0);
        chk("np_fd_noctrl_state", 64'(dbg_state), 64'(WAIT_EOF));
        chk("np_hold_len",        64'(bus.o_payload_length), 64'd20);
        chk("np_hold_intr",       64'(bus.o_interrupt), 64'd2);
        beat(EOF5_BEAT, 8'hE0);
        tick();
        chk("np_done", 64'(bus.o_done), 64'd1);
        chk("np_cnt",  64'(bus.o_frame_cnt), 64'd11);
        chk("np_gnt0", 64'(bus.o_gnt), 64'h0);
        beat(IDLE_BEAT, 8'hFF);
        tick(2);

        // Error set and clear in the same cycle: set wins
        bus.i_len[47:32] = 16'd0;
        bus.i_req        = 4'b0100;
        bus.i_clr_err    = 1'b1;
        tick();
        chk("setwins_err", 64'(bus.o_err_len), 64'd1);
        chk("setwins_gnt", 64'(bus.o_gnt), 64'h0);
        bus.i_clr_err    = 1'b0;
        bus.i_len[47:32] = 16'd64;
        tick();
        chk("rst_pre_gnt", 64'(bus.o_gnt), 64'h4);
        bus.i_req = '0;
        beat(SOF_BEAT, 8'h01);
        tick();
        chk("rst_pre_state", 64'(dbg_state), 64'(WAIT_EOF));
        beat(DATA_BEAT, 8'h00);

        // Asynchronous reset mid-frame
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        beat(IDLE_BEAT, 8'hFF);
        tick();
        rst_n     = 1'b1;
        bus.i_req = 4'b1111;
        bus.i_len = {16'd400, 16'd300, 16'd200, 16'd100};
        tick();
        chk("post_rst_gnt", 64'(bus.o_gnt), 64'h1);
        chk("post_rst_id",  64'(bus.o_active_id), 64'd0);
        chk("post_rst_len", 64'(bus.o_payload_length), 64'd100);
        chk("post_rst_cnt", 64'(bus.o_frame_cnt), 64'd0);
        bus.i_req = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
